// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem request at a time,
// buffers the returned word for decode and applies redirect/trap vectoring.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        trap,
  output logic [31:0] pc_actual
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;

  logic        kill;
  logic [31:0] target;

  // Trap wins over a simultaneous redirect
  assign kill   = trap | redirect;
  assign target = trap ? TRAP_VECTOR : {redirect_pc[31:2], 2'b00};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_VECTOR;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0;
      valid_q   <= 1'b0;
      instr_q   <= 32'h0;
      ifpc_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      ifpc_q    <= ifpc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ifpc_d    = ifpc_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (kill) pc_d = target;
      end
      FETCH: begin
        if (imem_ack) begin
          // A kill seen now or earlier turns the returning word into garbage
          if (kill) begin
            pc_d   = target;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end else if (kill) begin
          pend_d    = 1'b1;
          pend_pc_d = target;
        end
      end
      HOLD: begin
        if (kill) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = FETCH;
        end else if (id_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign pc_actual = pc_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;

endmodule
